// File: rtl/store_pkg.sv
// store_pkg: shared types and default sizes for the post-commit store buffer.
// INSTR_Q_WIDTH and NUM_ARCH_REGS stand in for the core-wide uop/register sizing.
package store_pkg;

    localparam int unsigned SB_DEPTH_DEFAULT = 16;
    localparam int unsigned INSTR_Q_WIDTH    = 4;
    localparam int unsigned NUM_ARCH_REGS    = 32;
    localparam int unsigned SB_ADDR_BITS     = 64;
    localparam int unsigned SB_WORD_SIZE     = 64;

    // Default-width buffer entry; the top re-declares it at its own parameter widths.
    typedef struct packed {
        logic [SB_ADDR_BITS-1:0] addr;
        logic [SB_WORD_SIZE-1:0] data;
    } sb_entry_t;

    typedef enum logic [0:0] {
        SB_IDLE,
        SB_SEND
    } sb_drain_state_t;

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo: circular buffer with a compacted multi-entry write and single-entry pop.
// Depth must be a power of two so the pointers wrap by natural overflow.
module sb_fifo
    import store_pkg::*;
#(
    parameter int unsigned Depth   = 16,
    parameter int unsigned WrLanes = 4,
    parameter type         entry_t = sb_entry_t,
    localparam int unsigned PtrW   = $clog2(Depth),
    localparam int unsigned CntW   = $clog2(Depth + 1),
    localparam int unsigned NumW   = $clog2(WrLanes + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [NumW-1:0]       i_wr_num,
    input  entry_t [WrLanes-1:0]  i_wr_data,
    input  logic                  i_pop,
    output logic [CntW-1:0]       o_count,
    output entry_t                o_head
);

    entry_t          r_mem [Depth];
    logic [PtrW-1:0] r_head;
    logic [PtrW-1:0] r_tail;
    logic [CntW-1:0] r_count;

    // Pointer and occupancy update; a write and a pop may land in the same cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PtrW'(i_pop);
            r_tail  <= r_tail + PtrW'(i_wr_num);
            r_count <= r_count + CntW'(i_wr_num) - CntW'(i_pop);
        end
    end

    // Entry storage: the first i_wr_num lanes land at consecutive slots from the tail.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < WrLanes; i++) begin
            if (NumW'(i) < i_wr_num) begin
                r_mem[r_tail + PtrW'(i)] <= i_wr_data[i];
            end
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_head];

endmodule

// File: rtl/store_commit_buffer.sv
// store_commit_buffer: post-commit store buffer between the ROB and the L1D.
// Captures committed store lanes, reads operands from the register file, compacts
// them into a FIFO and drains one store per handshake on the L1D request port.
// Optional macro STORE_BUF_PERF_EN adds handshake and stall counters.
module store_commit_buffer
    import store_pkg::*;
#(
    parameter int unsigned SB_DEPTH  = SB_DEPTH_DEFAULT,
    parameter int unsigned Q_WIDTH   = INSTR_Q_WIDTH,
    parameter int unsigned ADDR_BITS = 64,
    parameter int unsigned WORD_SIZE = 64,
    parameter int unsigned AREG_BITS = $clog2(NUM_ARCH_REGS),
    localparam int unsigned CNT_W    = $clog2(SB_DEPTH + 1),
    localparam int unsigned NUM_W    = $clog2(Q_WIDTH + 1)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [Q_WIDTH-1:0]             valid_str_in,
    input  logic [Q_WIDTH*AREG_BITS-1:0]   str_addr_reg_in,
    input  logic [Q_WIDTH*AREG_BITS-1:0]   str_addr_reg_off_in,
    input  logic [Q_WIDTH*AREG_BITS-1:0]   str_val_reg_in,
    output logic [CNT_W-1:0]               free_slots_out,
    output logic                           empty_out,
    output logic                           overflow_err_out,
`ifdef STORE_BUF_PERF_EN
    output logic [31:0]                    perf_stores_out,
    output logic [31:0]                    perf_stall_cycles_out,
`endif
    output logic                           rf_rd_en_out,
    output logic [Q_WIDTH*3*AREG_BITS-1:0] rf_rd_addr_out,
    input  logic [Q_WIDTH*3*WORD_SIZE-1:0] rf_rd_data_in,
    output logic                           mem_req_valid_out,
    input  logic                           mem_req_ready_in,
    output logic [ADDR_BITS-1:0]           mem_req_addr_out,
    output logic [WORD_SIZE-1:0]           mem_req_data_out
);

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [WORD_SIZE-1:0] data;
    } entry_t;

    logic [NUM_W-1:0]      w_popcnt;
    logic                  w_ovf;
    logic                  w_accept;
    logic [Q_WIDTH-1:0]    r_grp_valid;
    logic [NUM_W-1:0]      r_grp_num;
    logic [CNT_W-1:0]      r_free;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [CNT_W-1:0]      w_free_nxt;
    logic                  r_ovf;
    logic                  w_pop;
    entry_t [Q_WIDTH-1:0]  w_wr_data;
    entry_t                w_head;
    sb_drain_state_t       r_state;
    sb_drain_state_t       w_state_nxt;

    // Stage C: count the group, reject it whole if it does not fit, mirror read indices.
    always_comb begin
        w_popcnt       = '0;
        rf_rd_addr_out = '0;
        for (int i = 0; i < Q_WIDTH; i++) begin
            w_popcnt = w_popcnt + NUM_W'(valid_str_in[i]);
            rf_rd_addr_out[(3*i+2)*AREG_BITS +: AREG_BITS] =
                str_addr_reg_in[i*AREG_BITS +: AREG_BITS];
            rf_rd_addr_out[(3*i+1)*AREG_BITS +: AREG_BITS] =
                str_addr_reg_off_in[i*AREG_BITS +: AREG_BITS];
            rf_rd_addr_out[(3*i)*AREG_BITS +: AREG_BITS] =
                str_val_reg_in[i*AREG_BITS +: AREG_BITS];
        end
        w_ovf    = CNT_W'(w_popcnt) > r_free;
        w_accept = (|valid_str_in) && !w_ovf;
    end

    assign rf_rd_en_out = w_accept;

    // In-flight group register: holds the lane bitmap while register-file data returns.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_grp_valid <= '0;
            r_grp_num   <= '0;
        end else if (w_accept) begin
            r_grp_valid <= valid_str_in;
            r_grp_num   <= w_popcnt;
        end else begin
            r_grp_valid <= '0;
            r_grp_num   <= '0;
        end
    end

    // Stage W: compact valid lanes in ascending lane order into consecutive write slots.
    always_comb begin
        logic [NUM_W-1:0]     w_slot;
        logic [WORD_SIZE-1:0] w_base;
        logic [WORD_SIZE-1:0] w_off;
        logic [WORD_SIZE-1:0] w_sum;
        logic [WORD_SIZE-1:0] w_val;
        w_wr_data = '0;
        w_slot    = '0;
        w_base    = '0;
        w_off     = '0;
        w_sum     = '0;
        w_val     = '0;
        for (int i = 0; i < Q_WIDTH; i++) begin
            w_base = rf_rd_data_in[(3*i+2)*WORD_SIZE +: WORD_SIZE];
            w_off  = rf_rd_data_in[(3*i+1)*WORD_SIZE +: WORD_SIZE];
            w_val  = rf_rd_data_in[(3*i)*WORD_SIZE +: WORD_SIZE];
            // Sum wraps at WORD_SIZE before being resized to the address width.
            w_sum  = w_base + w_off;
            for (int j = 0; j < Q_WIDTH; j++) begin
                if (r_grp_valid[i] && (w_slot == NUM_W'(j))) begin
                    w_wr_data[j].addr = ADDR_BITS'(w_sum);
                    w_wr_data[j].data = w_val;
                end
            end
            w_slot = w_slot + NUM_W'(r_grp_valid[i]);
        end
    end

    sb_fifo #(
        .Depth   (SB_DEPTH),
        .WrLanes (Q_WIDTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_wr_num  (r_grp_num),
        .i_wr_data (w_wr_data),
        .i_pop     (w_pop),
        .o_count   (w_count),
        .o_head    (w_head)
    );

    assign w_pop = (r_state == SB_SEND) && mem_req_ready_in;

    // Next occupancy and free slots; the free count covers both FIFO and accepted group.
    always_comb begin
        w_count_nxt = w_count + CNT_W'(r_grp_num) - CNT_W'(w_pop);
        w_free_nxt  = CNT_W'(SB_DEPTH) - w_count_nxt - (w_accept ? CNT_W'(w_popcnt) : '0);
    end

    // Registered free-slot count and sticky overflow flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_free <= CNT_W'(SB_DEPTH);
            r_ovf  <= 1'b0;
        end else begin
            r_free <= w_free_nxt;
            if (w_ovf && (|valid_str_in)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= SB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM next state: stay in SEND while entries remain after a pop.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SB_IDLE: if (w_count != '0) w_state_nxt = SB_SEND;
            SB_SEND: if (w_pop && (w_count_nxt == '0)) w_state_nxt = SB_IDLE;
        endcase
    end

    // The head slot is register storage, so it stays stable until popped.
    always_comb begin
        mem_req_valid_out = (r_state == SB_SEND);
        mem_req_addr_out  = mem_req_valid_out ? w_head.addr : '0;
        mem_req_data_out  = mem_req_valid_out ? w_head.data : '0;
    end

    assign free_slots_out   = r_free;
    assign empty_out        = (w_count == '0) && (r_grp_num == '0);
    assign overflow_err_out = r_ovf;

`ifdef STORE_BUF_PERF_EN
    logic [31:0] r_perf_stores;
    logic [31:0] r_perf_stalls;

    // Wrapping counters for handshakes and back-pressured request cycles.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_perf_stores <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_pop) begin
                r_perf_stores <= r_perf_stores + 32'd1;
            end
            if (mem_req_valid_out && !mem_req_ready_in) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_stores_out       = r_perf_stores;
    assign perf_stall_cycles_out = r_perf_stalls;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: directed phases with randomized register contents,
// lane patterns and back-pressure, checked against a queue-based store model.
module tb_store_commit_buffer;

    localparam int unsigned QW    = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned W     = 64;
    localparam int unsigned DEPTH = 16;

    logic                clk_in;
    logic                rst_in;
    logic [QW-1:0]       valid_str_in;
    logic [QW*AW-1:0]    str_addr_reg_in;
    logic [QW*AW-1:0]    str_addr_reg_off_in;
    logic [QW*AW-1:0]    str_val_reg_in;
    logic [4:0]          free_slots_out;
    logic                empty_out;
    logic                overflow_err_out;
    logic                rf_rd_en_out;
    logic [QW*3*AW-1:0]  rf_rd_addr_out;
    logic [QW*3*W-1:0]   rf_rd_data_in;
    logic                mem_req_valid_out;
    logic                mem_req_ready_in;
    logic [W-1:0]        mem_req_addr_out;
    logic [W-1:0]        mem_req_data_out;
`ifdef STORE_BUF_PERF_EN
    logic [31:0]         perf_stores_out;
    logic [31:0]         perf_stall_cycles_out;
`endif

    store_commit_buffer dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .valid_str_in        (valid_str_in),
        .str_addr_reg_in     (str_addr_reg_in),
        .str_addr_reg_off_in (str_addr_reg_off_in),
        .str_val_reg_in      (str_val_reg_in),
        .free_slots_out      (free_slots_out),
        .empty_out           (empty_out),
        .overflow_err_out    (overflow_err_out),
`ifdef STORE_BUF_PERF_EN
        .perf_stores_out       (perf_stores_out),
        .perf_stall_cycles_out (perf_stall_cycles_out),
`endif
        .rf_rd_en_out        (rf_rd_en_out),
        .rf_rd_addr_out      (rf_rd_addr_out),
        .rf_rd_data_in       (rf_rd_data_in),
        .mem_req_valid_out   (mem_req_valid_out),
        .mem_req_ready_in    (mem_req_ready_in),
        .mem_req_addr_out    (mem_req_addr_out),
        .mem_req_data_out    (mem_req_data_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Architectural register file; read data returns the cycle after the strobe.
    logic [W-1:0] regs [32];

    always @(posedge clk_in) begin
        if (rf_rd_en_out) begin
            for (int i = 0; i < int'(QW * 3); i++) begin
                rf_rd_data_in[i*W +: W] <= regs[rf_rd_addr_out[i*AW +: AW]];
            end
        end
    end

    // Model state: expected stores in commit order plus accepted/drained totals.
    int unsigned  b_idx [QW];
    int unsigned  o_idx [QW];
    int unsigned  v_idx [QW];
    logic [2*W-1:0] exp_q [$];
    int           n_acc;
    int           n_hs;
    int           n_cmp;
    int           n_mis;
    bit           m_ovf;
    bit           p_valid;
    bit           p_ready;
    logic [W-1:0] p_addr;
    logic [W-1:0] p_data;
    logic         s_valid;
    logic         s_empty;
    logic         s_ovf;
    logic [4:0]   s_free;
    logic [W-1:0] s_addr;
    logic [W-1:0] s_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_idx();
        for (int i = 0; i < int'(QW); i++) begin
            b_idx[i] = $urandom_range(0, 31);
            o_idx[i] = $urandom_range(0, 31);
            v_idx[i] = $urandom_range(0, 31);
        end
    endtask

    task automatic rand_regs();
        for (int i = 0; i < 32; i++) begin
            regs[i] = {$urandom, $urandom};
        end
    endtask

    function automatic int model_free();
        return int'(DEPTH) - (n_acc - n_hs);
    endfunction

    // One clock cycle: drive at the falling edge, check 1 time unit later, then clock.
    task automatic step(input logic [QW-1:0] lanes, input logic rdy);
        int             free;
        int             pc;
        bit             acc;
        bit             hs;
        logic [2*W-1:0] head;
        logic [W-1:0]   sum;
        valid_str_in     = lanes;
        mem_req_ready_in = rdy;
        for (int i = 0; i < int'(QW); i++) begin
            str_addr_reg_in[i*AW +: AW]     = AW'(b_idx[i]);
            str_addr_reg_off_in[i*AW +: AW] = AW'(o_idx[i]);
            str_val_reg_in[i*AW +: AW]      = AW'(v_idx[i]);
        end
        #1;
        s_valid = mem_req_valid_out;
        s_empty = empty_out;
        s_ovf   = overflow_err_out;
        s_free  = free_slots_out;
        s_addr  = mem_req_addr_out;
        s_data  = mem_req_data_out;
        free = model_free();
        check("free_slots", free_slots_out, free);
        check("empty", empty_out, n_acc == n_hs);
        check("overflow_err", overflow_err_out, m_ovf);
        if (n_acc == n_hs) check("valid_without_pending", mem_req_valid_out, 0);
        if (p_valid && !p_ready) begin
            check("hold_valid", mem_req_valid_out, 1);
            check("hold_addr", mem_req_addr_out, p_addr);
            check("hold_data", mem_req_data_out, p_data);
        end
        hs = mem_req_valid_out && rdy;
        if (hs && exp_q.size() > 0) begin
            head = exp_q.pop_front();
            check("store_addr", mem_req_addr_out, head[2*W-1:W]);
            check("store_data", mem_req_data_out, head[W-1:0]);
        end
        pc  = $countones(lanes);
        acc = (pc != 0) && (pc <= free);
        if (pc > free) m_ovf = 1'b1;
        check("rf_rd_en", rf_rd_en_out, acc);
        if (acc) begin
            for (int i = 0; i < int'(QW); i++) begin
                if (lanes[i]) begin
                    sum = regs[b_idx[i]] + regs[o_idx[i]];
                    exp_q.push_back({sum, regs[v_idx[i]]});
                end
            end
        end
        p_valid = mem_req_valid_out;
        p_ready = rdy;
        p_addr  = mem_req_addr_out;
        p_data  = mem_req_data_out;
        @(posedge clk_in);
        if (acc) n_acc += pc;
        if (hs) n_hs++;
        @(negedge clk_in);
    endtask

    // Reset for one edge and check the state seen right after it.
    task automatic do_reset();
        rst_in           = 1'b1;
        valid_str_in     = '0;
        mem_req_ready_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("rst_valid", mem_req_valid_out, 0);
        check("rst_free", free_slots_out, DEPTH);
        check("rst_empty", empty_out, 1);
        check("rst_ovf", overflow_err_out, 0);
        check("rst_addr", mem_req_addr_out, 0);
`ifdef STORE_BUF_PERF_EN
        check("rst_perf_stores", perf_stores_out, 0);
        check("rst_perf_stalls", perf_stall_cycles_out, 0);
`endif
        @(negedge clk_in);
        rst_in = 1'b0;
        exp_q.delete();
        n_acc   = 0;
        n_hs    = 0;
        m_ovf   = 1'b0;
        p_valid = 1'b0;
        p_ready = 1'b0;
    endtask

    initial begin
        int rem;
        int hs0;
        int cyc;
        logic [QW-1:0] lanes;
        n_cmp = 0;
        n_mis = 0;
        rst_in = 1'b1;
        valid_str_in = '0;
        mem_req_ready_in = 1'b0;
        str_addr_reg_in = '0;
        str_addr_reg_off_in = '0;
        str_val_reg_in = '0;
        rf_rd_data_in = '0;
        rand_regs();
        rand_idx();
        @(negedge clk_in);
        do_reset();

        // Single store through lane 0: request appears three cycles after commit.
        regs[1] = 64'h1000;
        regs[2] = 64'h8;
        regs[3] = 64'hDEAD;
        b_idx[0] = 1;
        o_idx[0] = 2;
        v_idx[0] = 3;
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        check("single_t1_valid", s_valid, 0);
        step(4'b0000, 1'b0);
        check("single_t2_valid", s_valid, 0);
        step(4'b0000, 1'b0);
        check("single_t3_valid", s_valid, 1);
        check("single_addr", s_addr, 64'h1008);
        check("single_data", s_data, 64'hDEAD);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        check("single_done_valid", s_valid, 0);

        // Lanes 1 and 3 together drain on consecutive cycles, lane 1 first.
        rand_regs();
        rand_idx();
        step(4'b1010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("multi_t2_valid", s_valid, 0);
        step(4'b0000, 1'b1);
        check("multi_t3_valid", s_valid, 1);
        step(4'b0000, 1'b1);
        check("multi_t4_valid", s_valid, 1);
        step(4'b0000, 1'b1);
        check("multi_t5_valid", s_valid, 0);

        // Fill all 16 slots under back-pressure, then overflow with one more store.
        for (int g = 0; g < 4; g++) begin
            rand_regs();
            rand_idx();
            step(4'b1111, 1'b0);
        end
        step(4'b0000, 1'b0);
        check("full_free", s_free, 0);
        rand_idx();
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        check("overflow_set", s_ovf, 1);
        hs0 = n_hs;
        for (int c = 0; c < 40 && n_acc != n_hs; c++) step(4'b0000, 1'b1);
        check("full_handshakes", n_hs - hs0, 16);
        step(4'b0000, 1'b1);
        check("full_empty", s_empty, 1);
        do_reset();

        // Forty stores through the wrapping FIFO with random back-pressure.
        rem = 40;
        hs0 = n_hs;
        cyc = 0;
        while (rem > 0 && cyc < 400) begin
            lanes = QW'($urandom_range(0, 15));
            if ($countones(lanes) > rem || $countones(lanes) > model_free()) lanes = '0;
            rand_idx();
            if ($urandom_range(0, 3) == 0) rand_regs();
            step(lanes, 1'($urandom_range(0, 1)));
            rem -= $countones(lanes);
            cyc++;
        end
        check("wrap_all_committed", rem, 0);
        for (int c = 0; c < 400 && n_acc != n_hs; c++) step(4'b0000, 1'($urandom_range(0, 1)));
        step(4'b0000, 1'b0);
        check("wrap_empty", s_empty, 1);
        check("wrap_handshakes", n_hs - hs0, 40);

        // Reset while a request is held back by ready = 0.
        rand_regs();
        rand_idx();
        step(4'b0011, 1'b0);
        for (int c = 0; c < 10 && !s_valid; c++) step(4'b0000, 1'b0);
        check("middrain_valid_seen", s_valid, 1);
        do_reset();
        step(4'b0000, 1'b0);
        check("post_reset_valid", s_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
